wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage of the 5-stage MIPS pipeline: holds the MEM/WB boundary and drives the register-file write port consumed by the decode stage (WriteData/WriteRegister/WriteEnable).
- Merges two producers onto the single write port: in-order pipeline results, and out-of-order results from the multi-cycle mult/div unit via a valid/ready queue.
- Pipeline has priority. An anti-starvation counter briefly freezes the pipeline so queued results drain.

Parameters:
- DEPTH, 2, mult/div result queue entries (power of two, ≥2).
- STARVE_LIMIT, 4, cycles a non-empty queue head may wait before Stall_OUT asserts.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- MemValid_IN  input  1  MEM stage holds a real instruction (0 = bubble).
- MemALUResult_IN  input  32  ALU result / load address.
- MemReadData_IN  input  32  data-memory read word.
- MemRead_IN  input  1  instruction is a load.
- MemWriteRegister_IN  input  5  destination register.
- MemWriteEnable_IN  input  1  instruction writes a register.
- MemInstruction_IN  input  32  raw instruction (opcode used for load extension).
- MulDivValid_IN  input  1  mult/div result offered.
- MulDivData_IN  input  32  mult/div result value.
- MulDivRegister_IN  input  5  mult/div destination register.
- MulDivReady_OUT  output  1  queue accepts a result this cycle.
- WriteData_OUT  output  32  register-file write data, registered.
- WriteRegister_OUT  output  5  register-file write index, registered.
- WriteEnable_OUT  output  1  register-file write strobe, registered.
- Stall_OUT  output  1  registered; upstream holds the MEM stage this cycle.
- QueueCount_OUT  output  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (RESET=0, async):
  - WriteData_OUT=0, WriteRegister_OUT=0, WriteEnable_OUT=0, Stall_OUT=0.
  - Queue empty, QueueCount_OUT=0, starvation counter 0.
  - MulDivReady_OUT=0 while RESET=0.
  - Reset mid-operation discards queued entries; no write is issued for them.
- MulDivReady_OUT = RESET & (count < DEPTH), combinational.
- Push occurs on a rising edge when MulDivValid_IN & MulDivReady_OUT.
  - MulDivRegister_IN=0: handshake completes, nothing is enqueued.
- Pipeline write request P = MemValid_IN & MemWriteEnable_IN & (MemWriteRegister_IN != 0) & ~Stall_OUT.
- Pipeline write value = MemRead_IN ? load data : MemALUResult_IN.
- Each rising edge, the output registers load exactly one of, in priority order:
  1. P: pipeline value and register; WriteEnable_OUT<=1.
  2. Else queue non-empty: queue head; pop; WriteEnable_OUT<=1.
  3. Else: WriteEnable_OUT<=0; WriteData_OUT and WriteRegister_OUT hold their last values.
- Latency:
  - Pipeline result: inputs sampled at edge k, visible on the port in cycle k+1, committed by the register file at edge k+1.
  - Queue: an entry pushed at edge k is written at the earliest at edge k+1. There is no bypass from MulDiv inputs to the outputs.
- Simultaneous push and pop in one edge is legal; count is unchanged. Push is impossible when full because Ready=0.
- Queue pointers wrap modulo DEPTH.
- Starvation counter:
  - Increments each edge the queue is non-empty and no pop occurs.
  - Clears on pop or when the queue is empty.
  - When it reaches STARVE_LIMIT, Stall_OUT<=1 for exactly one cycle.
  - During that cycle the pipeline inputs are ignored (upstream repeats them next cycle), so the head pops. Stall_OUT then returns to 0 and the counter clears.
- Queue entries are written in FIFO order. No ordering guarantee is given between queue entries and pipeline results; hazards are resolved upstream.

Optional Feature:
- Macro WB_LOAD_EXTEND_EN.
- Defined: for loads, load data is extracted from MemReadData_IN (big-endian) by opcode MemInstruction_IN[31:26] and address MemALUResult_IN[1:0].
  - 0x20 LB: sign-extended byte; lane 0 = bits[31:24].
  - 0x24 LBU: zero-extended byte.
  - 0x21 LH: sign-extended halfword; addr[1]=0 selects bits[31:16].
  - 0x25 LHU: zero-extended halfword.
  - All other load opcodes: full word.
- Not defined: load data = MemReadData_IN unmodified for every load.

Test Plan:
- Reset release, then pipeline ALU write (reg 5, 0x0000_1234, MemValid=1) -> next cycle WriteEnable_OUT=1, WriteRegister_OUT=5, WriteData_OUT=0x1234.
- MemWriteRegister_IN=0 with MemWriteEnable_IN=1 and queue empty -> WriteEnable_OUT stays 0.
- Push mult/div (reg 9, 0xDEAD_BEEF) while pipeline idle -> written the cycle after push; QueueCount_OUT returns to 0.
- DEPTH=2: push two results while the pipeline writes every cycle -> MulDivReady_OUT=0 at count 2. After 4 waiting edges Stall_OUT=1 for one cycle, the head is written, and Ready returns to 1.
- With WB_LOAD_EXTEND_EN: LB, MemReadData_IN=0x80FF_0102, addr[1:0]=0 -> WriteData_OUT=0xFFFF_FF80. LHU, addr[1:0]=2 -> 0x0000_0102.
- Assert RESET low with 2 entries queued -> count=0, WriteEnable_OUT=0 immediately. No queued write appears after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter -- writeback stage of the 5-stage MIPS pipeline.
//
// Holds the MEM/WB boundary and drives the register-file write port. There are
// two producers. In-order pipeline results always win. Out-of-order results
// from the mult/div unit wait in a small FIFO and are written on cycles where
// the pipeline does not write. If the FIFO head waits STARVE_LIMIT edges, the
// block raises Stall_OUT for one cycle. During that cycle the pipeline inputs
// are ignored, so the head pops.
//
// Optional feature macro: WB_LOAD_EXTEND_EN
//   When it is defined, load data is byte/halfword extracted (big-endian) by
//   opcode and address. When it is not defined, loads return the raw memory
//   word.
//
// Parameters:
//   DEPTH        mult/div queue entries (power of two, >= 2)
//   STARVE_LIMIT waiting edges allowed before Stall_OUT asserts
//
// Ports:
//   CLOCK, RESET            clock (rising edge), async active-low reset
//   Mem*_IN                 MEM-stage instruction: valid, ALU result/address,
//                           read data, load flag, dest reg, write enable, raw
//                           instruction
//   MulDivValid/Data/Register_IN, MulDivReady_OUT
//                           valid/ready push port into the result queue
//   WriteData/Register/Enable_OUT
//                           registered register-file write port
//   Stall_OUT               registered; upstream holds the MEM stage
//   QueueCount_OUT          current queue occupancy
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     MemValid_IN,
    input  logic [31:0]              MemALUResult_IN,
    input  logic [31:0]              MemReadData_IN,
    input  logic                     MemRead_IN,
    input  logic [4:0]               MemWriteRegister_IN,
    input  logic                     MemWriteEnable_IN,
    input  logic [31:0]              MemInstruction_IN,
    input  logic                     MulDivValid_IN,
    input  logic [31:0]              MulDivData_IN,
    input  logic [4:0]               MulDivRegister_IN,
    output logic                     MulDivReady_OUT,
    output logic [31:0]              WriteData_OUT,
    output logic [4:0]               WriteRegister_OUT,
    output logic                     WriteEnable_OUT,
    output logic                     Stall_OUT,
    output logic [$clog2(DEPTH):0]   QueueCount_OUT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_STOP = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  regIdx;
    } qEntry_t;

    qEntry_t         queueMem [DEPTH];
    logic [PW-1:0]   wrPtr, rdPtr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starveCnt;
    logic [SW-1:0]   starveInc;

    logic            queueNonEmpty;
    logic            push, pop, pipeReq;
    logic [31:0]     loadData, pipeValue;
    qEntry_t         head;

    // ---------------- load data path ----------------
`ifdef WB_LOAD_EXTEND_EN
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        // Big-endian: byte lane 0 is the most significant byte.
        loadByte = MemReadData_IN[31:24];
        case (MemALUResult_IN[1:0])
            2'd0:    loadByte = MemReadData_IN[31:24];
            2'd1:    loadByte = MemReadData_IN[23:16];
            2'd2:    loadByte = MemReadData_IN[15:8];
            default: loadByte = MemReadData_IN[7:0];
        endcase
        loadHalf = MemALUResult_IN[1] ? MemReadData_IN[15:0] : MemReadData_IN[31:16];

        loadData = MemReadData_IN;
        case (MemInstruction_IN[31:26])
            6'h20:   loadData = {{24{loadByte[7]}}, loadByte};   // LB
            6'h24:   loadData = {24'h0, loadByte};               // LBU
            6'h21:   loadData = {{16{loadHalf[15]}}, loadHalf};  // LH
            6'h25:   loadData = {16'h0, loadHalf};               // LHU
            default: loadData = MemReadData_IN;
        endcase
    end
`else
    logic unusedInstr;
    assign unusedInstr = ^MemInstruction_IN;
    assign loadData    = MemReadData_IN;
`endif

    assign pipeValue = MemRead_IN ? loadData : MemALUResult_IN;

    // ---------------- arbitration ----------------
    assign queueNonEmpty   = (count != '0);
    assign MulDivReady_OUT = RESET & (count < FULL_COUNT);
    // A register-0 result completes the handshake but is never stored.
    assign push    = MulDivValid_IN & MulDivReady_OUT & (MulDivRegister_IN != 5'd0);
    // Stall_OUT means the pipeline inputs are a repeat that upstream will
    // present again next cycle, so they are ignored for this cycle.
    assign pipeReq = MemValid_IN & MemWriteEnable_IN & (MemWriteRegister_IN != 5'd0) & ~Stall_OUT;
    assign pop     = ~pipeReq & queueNonEmpty;
    assign head    = queueMem[rdPtr];
    assign starveInc      = starveCnt + 1'b1;
    assign QueueCount_OUT = count;

    // Queue storage needs no reset. Occupancy is tracked by count alone.
    always_ff @(posedge CLOCK) begin
        if (push) queueMem[wrPtr] <= '{data: MulDivData_IN, regIdx: MulDivRegister_IN};
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            WriteData_OUT     <= '0;
            WriteRegister_OUT <= '0;
            WriteEnable_OUT   <= 1'b0;
            Stall_OUT         <= 1'b0;
            count             <= '0;
            wrPtr             <= '0;
            rdPtr             <= '0;
            starveCnt         <= '0;
        end else begin
            if (pipeReq) begin
                WriteData_OUT     <= pipeValue;
                WriteRegister_OUT <= MemWriteRegister_IN;
                WriteEnable_OUT   <= 1'b1;
            end else if (queueNonEmpty) begin
                WriteData_OUT     <= head.data;
                WriteRegister_OUT <= head.regIdx;
                WriteEnable_OUT   <= 1'b1;
            end else begin
                WriteEnable_OUT   <= 1'b0;
            end

            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // The stall cycle always pops: pipeReq is masked and the queue
            // is non-empty. This keeps starveCnt from running past the limit.
            if (pop || !queueNonEmpty) starveCnt <= '0;
            else                       starveCnt <= starveInc;

            Stall_OUT <= queueNonEmpty & ~pop & (starveInc == STARVE_STOP);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_arbiter;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        MemValid_IN = 1'b0;
    logic [31:0] MemALUResult_IN = '0;
    logic [31:0] MemReadData_IN = '0;
    logic        MemRead_IN = 1'b0;
    logic [4:0]  MemWriteRegister_IN = '0;
    logic        MemWriteEnable_IN = 1'b0;
    logic [31:0] MemInstruction_IN = '0;
    logic        MulDivValid_IN = 1'b0;
    logic [31:0] MulDivData_IN = '0;
    logic [4:0]  MulDivRegister_IN = '0;
    logic        MulDivReady_OUT;
    logic [31:0] WriteData_OUT;
    logic [4:0]  WriteRegister_OUT;
    logic        WriteEnable_OUT;
    logic        Stall_OUT;
    logic [1:0]  QueueCount_OUT;

    int total = 0;
    int bad   = 0;

    wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .MemValid_IN(MemValid_IN), .MemALUResult_IN(MemALUResult_IN),
        .MemReadData_IN(MemReadData_IN), .MemRead_IN(MemRead_IN),
        .MemWriteRegister_IN(MemWriteRegister_IN), .MemWriteEnable_IN(MemWriteEnable_IN),
        .MemInstruction_IN(MemInstruction_IN),
        .MulDivValid_IN(MulDivValid_IN), .MulDivData_IN(MulDivData_IN),
        .MulDivRegister_IN(MulDivRegister_IN), .MulDivReady_OUT(MulDivReady_OUT),
        .WriteData_OUT(WriteData_OUT), .WriteRegister_OUT(WriteRegister_OUT),
        .WriteEnable_OUT(WriteEnable_OUT), .Stall_OUT(Stall_OUT),
        .QueueCount_OUT(QueueCount_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pipe(input logic v, input logic [4:0] r, input logic [31:0] alu);
        MemValid_IN = v; MemWriteEnable_IN = v; MemWriteRegister_IN = r;
        MemALUResult_IN = alu; MemRead_IN = 1'b0;
    endtask

    task automatic md(input logic v, input logic [4:0] r, input logic [31:0] d);
        MulDivValid_IN = v; MulDivRegister_IN = r; MulDivData_IN = d;
    endtask

    initial begin
        // ---- reset ----
        #2 RESET = 1'b0;
        #1;
        check("rst_we",    32'(WriteEnable_OUT),   32'd0);
        check("rst_data",  WriteData_OUT,          32'd0);
        check("rst_reg",   32'(WriteRegister_OUT), 32'd0);
        check("rst_stall", 32'(Stall_OUT),         32'd0);
        check("rst_count", 32'(QueueCount_OUT),    32'd0);
        check("rst_ready", 32'(MulDivReady_OUT),   32'd0);
        #17 RESET = 1'b1;             // mid-cycle release (t=20)
        #1;
        check("rel_ready", 32'(MulDivReady_OUT),   32'd1);

        // ---- pipeline ALU write ----
        pipe(1'b1, 5'd5, 32'h0000_1234);
        tick();
        check("alu_we",   32'(WriteEnable_OUT),   32'd1);
        check("alu_reg",  32'(WriteRegister_OUT), 32'd5);
        check("alu_data", WriteData_OUT,          32'h0000_1234);
        pipe(1'b0, 5'd0, 32'h0);
        tick();
        check("idle_we",   32'(WriteEnable_OUT),   32'd0);
        check("hold_data", WriteData_OUT,          32'h0000_1234);
        check("hold_reg",  32'(WriteRegister_OUT), 32'd5);

        // ---- register 0 never writes ----
        pipe(1'b1, 5'd0, 32'h5555_5555);
        tick();
        check("r0_we",   32'(WriteEnable_OUT), 32'd0);
        check("r0_data", WriteData_OUT,        32'h0000_1234);
        pipe(1'b0, 5'd0, 32'h0);

        // ---- single mult/div result ----
        md(1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        check("md_push_count", 32'(QueueCount_OUT),  32'd1);
        check("md_no_bypass",  32'(WriteEnable_OUT), 32'd0);
        md(1'b0, 5'd0, 32'h0);
        tick();
        check("md_we",    32'(WriteEnable_OUT),   32'd1);
        check("md_reg",   32'(WriteRegister_OUT), 32'd9);
        check("md_data",  WriteData_OUT,          32'hDEAD_BEEF);
        check("md_count", 32'(QueueCount_OUT),    32'd0);
        tick();
        check("md_after_we", 32'(WriteEnable_OUT), 32'd0);

        // ---- mult/div to register 0: handshake only ----
        md(1'b1, 5'd0, 32'h1111_1111);
        check("md_r0_ready", 32'(MulDivReady_OUT), 32'd1);
        tick();
        check("md_r0_count", 32'(QueueCount_OUT), 32'd0);
        md(1'b0, 5'd0, 32'h0);
        tick();
        check("md_r0_we", 32'(WriteEnable_OUT), 32'd0);

        // ---- starvation: pipeline writes every cycle, queue fills ----
        pipe(1'b1, 5'd3, 32'h0000_0100);
        md(1'b1, 5'd10, 32'h0000_000A);
        tick();                                     // e1: push A
        check("st_e1_count", 32'(QueueCount_OUT),    32'd1);
        check("st_e1_reg",   32'(WriteRegister_OUT), 32'd3);
        md(1'b1, 5'd11, 32'h0000_000B);
        tick();                                     // e2: push B
        check("st_e2_count", 32'(QueueCount_OUT),  32'd2);
        check("st_full_rdy", 32'(MulDivReady_OUT), 32'd0);
        md(1'b0, 5'd0, 32'h0);
        tick();                                     // e3
        check("st_e3_stall", 32'(Stall_OUT), 32'd0);
        tick();                                     // e4
        check("st_e4_stall", 32'(Stall_OUT), 32'd0);
        tick();                                     // e5: 4th waiting edge
        check("st_e5_stall", 32'(Stall_OUT),         32'd1);
        check("st_e5_reg",   32'(WriteRegister_OUT), 32'd3);
        tick();                                     // e6: head popped
        check("st_e6_stall", 32'(Stall_OUT),         32'd0);
        check("st_e6_we",    32'(WriteEnable_OUT),   32'd1);
        check("st_e6_reg",   32'(WriteRegister_OUT), 32'd10);
        check("st_e6_data",  WriteData_OUT,          32'h0000_000A);
        check("st_e6_count", 32'(QueueCount_OUT),    32'd1);
        check("st_e6_ready", 32'(MulDivReady_OUT),   32'd1);
        tick();                                     // e7: pipeline resumes
        check("st_e7_reg",  32'(WriteRegister_OUT), 32'd3);
        check("st_e7_data", WriteData_OUT,          32'h0000_0100);

        // ---- reset with two entries queued ----
        md(1'b1, 5'd12, 32'h0000_000C);
        tick();
        check("rq_count2", 32'(QueueCount_OUT), 32'd2);
        md(1'b0, 5'd0, 32'h0);
        pipe(1'b0, 5'd0, 32'h0);
        RESET = 1'b0;
        #1;
        check("rq_count0", 32'(QueueCount_OUT),  32'd0);
        check("rq_we0",    32'(WriteEnable_OUT), 32'd0);
        check("rq_ready0", 32'(MulDivReady_OUT), 32'd0);
        #3 RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rq_no_write", 32'(WriteEnable_OUT), 32'd0);
            check("rq_empty",    32'(QueueCount_OUT),  32'd0);
        end

        // ---- loads ----
        MemValid_IN = 1'b1; MemWriteEnable_IN = 1'b1; MemRead_IN = 1'b1;
        MemWriteRegister_IN = 5'd7;
        MemReadData_IN = 32'h80FF_0102;
        MemALUResult_IN = 32'h0000_0000;
        MemInstruction_IN = {6'h20, 26'h0};        // LB
        tick();
`ifdef WB_LOAD_EXTEND_EN
        check("ld_lb",  WriteData_OUT, 32'hFFFF_FF80);
`else
        check("ld_lb",  WriteData_OUT, 32'h80FF_0102);
`endif
        check("ld_reg", 32'(WriteRegister_OUT), 32'd7);
        MemALUResult_IN = 32'h0000_0002;
        MemInstruction_IN = {6'h25, 26'h0};        // LHU
        tick();
`ifdef WB_LOAD_EXTEND_EN
        check("ld_lhu", WriteData_OUT, 32'h0000_0102);
`else
        check("ld_lhu", WriteData_OUT, 32'h80FF_0102);
`endif
        MemValid_IN = 1'b0; MemRead_IN = 1'b0;
        tick();
        check("ld_idle_we", 32'(WriteEnable_OUT), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
